// File: rtl/s1_frame_tx_if.sv
// Bus bundle for s1_frame_tx: the RB1 register-bank port and the sen/sd serial link.
// The transmitter uses the master view, and the bank/receiver side uses the slave view.
interface s1_frame_tx_if;
    logic       RB1_RW;
    logic [4:0] RB1_A;
    logic [7:0] RB1_D;
    logic [7:0] RB1_Q;
    logic       sen;
    logic       sd;

    modport master (output RB1_RW, RB1_A, RB1_D, sen, sd, input RB1_Q);
    modport slave  (input RB1_RW, RB1_A, RB1_D, sen, sd, output RB1_Q);
endinterface

// File: rtl/s1_frame_tx.sv
// S1 frame transmitter: loads 18x8 bits from RB1, then sends eight 21-bit bit-plane frames on sen/sd.
// Optional feature macro: S1_LONG_GAP_EN stretches the inter-frame gap from 2 to 4 cycles.
module s1_frame_tx (
    input  logic              clk,
    input  logic              rst,
    output logic              S1_done,
    s1_frame_tx_if.master     bus
);

`ifdef S1_LONG_GAP_EN
    localparam logic [1:0] GAP_LAST = 2'd3;
`else
    localparam logic [1:0] GAP_LAST = 2'd1;
`endif

    localparam logic [4:0] LOAD_LAST = 5'd18;
    localparam logic [4:0] ADDR_LAST = 5'd17;
    localparam logic [4:0] BIT_LAST  = 5'd20;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] frame_buf [18];
    logic [2:0] frame_idx;
    logic [4:0] bit_cnt;
    logic [4:0] load_cnt;
    logic [1:0] gap_cnt;

    logic [4:0] next_bit;
    logic [4:0] data_idx;
    logic [2:0] frame_inc;
    logic       next_sd;

    // The block only ever reads RB1, so the access type and write data are fixed.
    assign bus.RB1_RW = 1'b1;
    assign bus.RB1_D  = 8'h00;

    assign next_bit  = bit_cnt + 5'd1;
    assign data_idx  = next_bit - 5'd3;
    assign frame_inc = frame_idx + 3'd1;

    // Serial bit k of frame j: k<3 is the address (MSB first), then buf[k-3][7-j].
    always_comb begin
        // NOTE: default assignment first so that no path through the block infers a latch.
        next_sd = 1'b0;
        if (next_bit == 5'd1) begin
            next_sd = frame_idx[1];
        end else if (next_bit == 5'd2) begin
            next_sd = frame_idx[0];
        end else if (next_bit >= 5'd3 && next_bit <= BIT_LAST) begin
            next_sd = frame_buf[data_idx][~frame_idx];
        end
    end

    // NOTE: the buffer has no reset; its contents are don't-care until LOAD rewrites all 18 entries.
    always_ff @(posedge clk) begin
        if (state == LOAD && load_cnt != 5'd0) begin
            frame_buf[load_cnt - 5'd1] <= bus.RB1_Q;
        end
    end

    // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            frame_idx <= 3'd0;
            bit_cnt   <= 5'd0;
            load_cnt  <= 5'd0;
            gap_cnt   <= 2'd0;
            bus.RB1_A <= 5'd0;
            bus.sen   <= 1'b1;
            bus.sd    <= 1'b0;
            S1_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= LOAD;
                    load_cnt  <= 5'd0;
                    bus.RB1_A <= 5'd0;
                end

                LOAD: begin
                    if (load_cnt < ADDR_LAST) begin
                        bus.RB1_A <= load_cnt + 5'd1;
                    end
                    // The last read data arrives one cycle after address 17, hence 19 LOAD cycles.
                    if (load_cnt == LOAD_LAST) begin
                        state     <= SEND;
                        frame_idx <= 3'd0;
                        bit_cnt   <= 5'd0;
                        bus.sen   <= 1'b0;
                        bus.sd    <= 1'b0;
                    end else begin
                        load_cnt <= load_cnt + 5'd1;
                    end
                end

                SEND: begin
                    if (bit_cnt == BIT_LAST) begin
                        bus.sen <= 1'b1;
                        bus.sd  <= 1'b0;
                        if (frame_idx == 3'd7) begin
                            state   <= DONE;
                            S1_done <= 1'b1;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= 2'd0;
                        end
                    end else begin
                        bit_cnt <= next_bit;
                        bus.sd  <= next_sd;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state     <= SEND;
                        frame_idx <= frame_inc;
                        bit_cnt   <= 5'd0;
                        bus.sen   <= 1'b0;
                        bus.sd    <= frame_inc[2];
                    end else begin
                        gap_cnt <= gap_cnt + 2'd1;
                    end
                end

                DONE: begin
                    bus.sen <= 1'b1;
                    bus.sd  <= 1'b0;
                    S1_done <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s1_frame_tx.sv
// Directed bench for s1_frame_tx: RB1 bank model, per-cycle output trace and a behavioural S2-style receiver.
module tb_s1_frame_tx;

`ifdef S1_LONG_GAP_EN
    localparam int GAP_LEN = 4;
`else
    localparam int GAP_LEN = 2;
`endif
    localparam int FRAME_PERIOD = 21 + GAP_LEN;
    localparam int DONE_CYCLE   = 20 + 8 * 21 + 7 * GAP_LEN;
    localparam int NCYC         = DONE_CYCLE + 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic S1_done;

    s1_frame_tx_if bus ();

    s1_frame_tx dut (
        .clk     (clk),
        .rst     (rst),
        .S1_done (S1_done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // RB1 bank: read data valid the cycle after the address.
    logic [7:0] mem [18];
    always @(posedge clk) begin
        bus.RB1_Q <= (bus.RB1_A < 5'd18) ? mem[bus.RB1_A] : 8'h00;
    end

    // Receiver: shifts sd while sen is low, stores a frame when sen rises after 21 bits.
    logic [17:0] rb2 [8];
    logic [20:0] rx_shift;
    int          rx_cnt;
    int          rx_frames;
    always @(posedge clk) begin
        if (rst) begin
            rx_cnt    <= 0;
            rx_frames <= 0;
            for (int i = 0; i < 8; i++) rb2[i] <= 18'h3FFFF;
        end else if (!bus.sen) begin
            rx_shift <= {rx_shift[19:0], bus.sd};
            rx_cnt   <= rx_cnt + 1;
        end else begin
            if (rx_cnt == 21) begin
                rb2[rx_shift[20:18]] <= rx_shift[17:0];
                rx_frames            <= rx_frames + 1;
            end
            rx_cnt <= 0;
        end
    end

    // Per-cycle trace, cycle 0 = first cycle with rst sampled low.
    logic       sen_tr  [NCYC];
    logic       sd_tr   [NCYC];
    logic       done_tr [NCYC];
    logic [4:0] a_tr    [NCYC];

    int checks = 0;
    int errors = 0;

    logic [17:0] pat_exp [8];

    task automatic capture();
        for (int c = 0; c < NCYC; c++) begin
            if (c > 0) @(negedge clk);
            sen_tr[c]  = bus.sen;
            sd_tr[c]   = bus.sd;
            done_tr[c] = S1_done;
            a_tr[c]    = bus.RB1_A;
        end
    endtask

    task automatic start_run();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        capture();
    endtask

    function automatic logic [20:0] get_frame(input int j);
        logic [20:0] w = '0;
        int s = 20 + FRAME_PERIOD * j;
        for (int k = 0; k < 21; k++) w = {w[19:0], sd_tr[s + k]};
        return w;
    endfunction

    function automatic logic sen_window_ok(input int j);
        int s = 20 + FRAME_PERIOD * j;
        logic ok = sen_tr[s - 1] && sen_tr[s + 21];
        for (int k = 0; k < 21; k++) if (sen_tr[s + k] !== 1'b0) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic sd_quiet_ok();
        logic ok = 1'b1;
        for (int c = 0; c < NCYC; c++) if (sen_tr[c] && sd_tr[c] !== 1'b0) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [2:0] done_shape();
        return {done_tr[DONE_CYCLE - 1], done_tr[DONE_CYCLE], done_tr[NCYC - 1]};
    endfunction

    task automatic test_reset();
        for (int m = 0; m < 18; m++) mem[m] = 8'(m);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.sen !== 1'b1)    begin errors++; $display("FAIL reset_sen: got %b expected 1", bus.sen); end
        checks++; if (bus.sd !== 1'b0)     begin errors++; $display("FAIL reset_sd: got %b expected 0", bus.sd); end
        checks++; if (S1_done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b expected 0", S1_done); end
        checks++; if (bus.RB1_RW !== 1'b1) begin errors++; $display("FAIL reset_rw: got %b expected 1", bus.RB1_RW); end
        checks++; if (bus.RB1_A !== 5'd0)  begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.RB1_A); end
        checks++; if (bus.RB1_D !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h expected 00", bus.RB1_D); end
        rst = 1'b0;
        capture();
        for (int c = 1; c <= 18; c++) begin
            checks++;
            if (a_tr[c] !== 5'(c - 1)) begin
                errors++; $display("FAIL load_addr cycle %0d: got %0d expected %0d", c, a_tr[c], c - 1);
            end
        end
        checks++; if (a_tr[19] !== 5'd17 || a_tr[NCYC - 1] !== 5'd17) begin
            errors++; $display("FAIL addr_hold: got %0d/%0d expected 17/17", a_tr[19], a_tr[NCYC - 1]);
        end
        checks++; if (sen_tr[19] !== 1'b1 || sen_tr[20] !== 1'b0) begin
            errors++; $display("FAIL first_sen: got %b%b expected 10", sen_tr[19], sen_tr[20]);
        end
    endtask

    task automatic test_all_ones();
        for (int m = 0; m < 18; m++) mem[m] = 8'hFF;
        start_run();
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (get_frame(j) !== {3'(j), 18'h3FFFF}) begin
                errors++; $display("FAIL ones_frame%0d: got %h expected %h", j, get_frame(j), {3'(j), 18'h3FFFF});
            end
            checks++;
            if (sen_window_ok(j) !== 1'b1) begin
                errors++; $display("FAIL ones_sen_window%0d: got 0 expected 1", j);
            end
        end
        checks++; if (sd_quiet_ok() !== 1'b1) begin errors++; $display("FAIL ones_sd_quiet: got 0 expected 1"); end
        checks++; if (done_shape() !== 3'b011) begin
            errors++; $display("FAIL ones_done_cycle: got %b expected 011", done_shape());
        end
    endtask

    task automatic test_single_bit();
        for (int m = 0; m < 18; m++) mem[m] = 8'h00;
        mem[0] = 8'h80;
        start_run();
        for (int j = 0; j < 8; j++) begin
            logic [17:0] exp_d = (j == 0) ? 18'h20000 : 18'h00000;
            checks++;
            if (get_frame(j) !== {3'(j), exp_d}) begin
                errors++; $display("FAIL single_frame%0d: got %h expected %h", j, get_frame(j), {3'(j), exp_d});
            end
        end
    endtask

    task automatic test_pattern();
        for (int m = 0; m < 18; m++) mem[m] = 8'(m);
        start_run();
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (get_frame(j) !== {3'(j), pat_exp[j]}) begin
                errors++; $display("FAIL pattern_frame%0d: got %h expected %h", j, get_frame(j), {3'(j), pat_exp[j]});
            end
        end
        checks++; if (sd_quiet_ok() !== 1'b1) begin errors++; $display("FAIL pattern_sd_quiet: got 0 expected 1"); end
    endtask

    task automatic test_mid_reset();
        for (int m = 0; m < 18; m++) mem[m] = 8'(m);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        checks++; if (bus.sen !== 1'b0) begin errors++; $display("FAIL mid_in_frame: got %b expected 0", bus.sen); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.sen !== 1'b1)   begin errors++; $display("FAIL mid_sen: got %b expected 1", bus.sen); end
        checks++; if (bus.sd !== 1'b0)    begin errors++; $display("FAIL mid_sd: got %b expected 0", bus.sd); end
        checks++; if (bus.RB1_A !== 5'd0) begin errors++; $display("FAIL mid_addr: got %0d expected 0", bus.RB1_A); end
        rst = 1'b0;
        capture();
        checks++; if (a_tr[1] !== 5'd0 || a_tr[18] !== 5'd17) begin
            errors++; $display("FAIL mid_restart_addr: got %0d/%0d expected 0/17", a_tr[1], a_tr[18]);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (get_frame(j) !== {3'(j), pat_exp[j]}) begin
                errors++; $display("FAIL mid_frame%0d: got %h expected %h", j, get_frame(j), {3'(j), pat_exp[j]});
            end
        end
        checks++; if (done_shape() !== 3'b011) begin
            errors++; $display("FAIL mid_done_cycle: got %b expected 011", done_shape());
        end
    endtask

    task automatic test_loopback();
        for (int m = 0; m < 18; m++) mem[m] = 8'(m);
        start_run();
        checks++; if (rx_frames !== 8) begin errors++; $display("FAIL loop_frames: got %0d expected 8", rx_frames); end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (rb2[j] !== pat_exp[j]) begin
                errors++; $display("FAIL loop_rb2_%0d: got %h expected %h", j, rb2[j], pat_exp[j]);
            end
        end
        checks++; if (done_shape() !== 3'b011) begin
            errors++; $display("FAIL loop_done_cycle: got %b expected 011", done_shape());
        end
    endtask

    initial begin
        // RB1[m] = m: frame j carries bit (7-j) of m at data bit (17-m).
        pat_exp[0] = 18'h00000;
        pat_exp[1] = 18'h00000;
        pat_exp[2] = 18'h00000;
        pat_exp[3] = 18'h00003;
        pat_exp[4] = 18'h003FC;
        pat_exp[5] = 18'h03C3C;
        pat_exp[6] = 18'h0CCCC;
        pat_exp[7] = 18'h15555;

        test_reset();
        test_all_ones();
        test_single_bit();
        test_pattern();
        test_mid_reset();
        test_loopback();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
